// File: rtl/sha_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha_pkg: shared SHA-256 state encoding, K round constants and IV words. Rev 1.0
// ---------------------------------------------------------------------------
package sha_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ROUND  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } sha_state_e;

  // Index 0 is the leftmost entry of each table.
  localparam logic [0:63][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV_TABLE = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage
`default_nettype wire

// File: rtl/sha_round_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha_round_counter: 6-bit round counter with clear/enable and last flag. Rev 1.0
// ---------------------------------------------------------------------------
module sha_round_counter #(
  parameter int LAST_IDX = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [5:0] cnt_o,
  output logic       last_o
);

  logic [5:0] cnt_q;
  logic [5:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 6'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == 6'(LAST_IDX));

endmodule
`default_nettype wire

// File: rtl/sha_round_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha_round_ctrl: sequences one SHA-256 block (load, 64 rounds, H update). Rev 1.0
// ---------------------------------------------------------------------------
module sha_round_ctrl
  import sha_pkg::*;
#(
  parameter int NUM_ROUNDS  = 64,
  parameter int SCHED_FIRST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic        blk_first,
  input  logic        blk_last,
  input  logic        abort,
  output logic        load_initial,
  output logic [7:0]  sched_idx,
  output logic        sched_en,
  output logic        round_en,
  output logic [5:0]  round_idx,
  output logic [31:0] k_out,
  output logic        init_h,
  output logic        update_h,
  output logic        hash_valid,
  input  logic        hash_ready
);

  localparam logic [5:0] c_SCHED_FIRST = 6'(SCHED_FIRST);

  sha_state_e state_q, state_d;
  logic       first_q, first_d;
  logic       last_q,  last_d;

  logic [5:0] w_cnt;
  logic       w_cnt_last;
  logic       w_in_round;
  logic       w_accept;

  assign w_in_round = (state_q == ST_ROUND);
  assign w_accept   = start_valid && start_ready;

  // Counter is held at zero outside ROUND, so leaving after 63 never wraps into a 65th round.
  sha_round_counter #(
    .LAST_IDX (NUM_ROUNDS - 1)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (abort || !w_in_round || w_cnt_last),
    .en_i   (w_in_round),
    .cnt_o  (w_cnt),
    .last_o (w_cnt_last)
  );

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d = ST_LOAD;
          first_d = blk_first;
          last_d  = blk_last;
        end
      end
      ST_LOAD:   state_d = ST_ROUND;
      ST_ROUND:  if (w_cnt_last) state_d = ST_UPDATE;
      ST_UPDATE: state_d = last_q ? ST_DONE : ST_IDLE;
      ST_DONE:   if (hash_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      first_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign start_ready  = (state_q == ST_IDLE) && !abort && !rst;
  assign load_initial = (state_q == ST_LOAD);
  assign init_h       = (state_q == ST_LOAD) && first_q;
  assign round_en     = w_in_round;
  assign round_idx    = w_cnt;
  assign sched_idx    = {2'b00, w_cnt};
  assign sched_en     = w_in_round && (w_cnt >= c_SCHED_FIRST);
  assign k_out        = w_in_round ? K_TABLE[w_cnt] : K_TABLE[0];
  // A cancelled block must never touch H or present a digest.
  assign update_h     = (state_q == ST_UPDATE) && !abort;
  assign hash_valid   = (state_q == ST_DONE) && !abort;

endmodule
`default_nettype wire

// File: doc/sha_round_ctrl.md
SHA_ROUND_CTRL -- requirements
Module: sha_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 64, meaning compression rounds per 512-bit block; legal value 64 only.
REQ-002 SHALL have parameter SCHED_FIRST, default 16, meaning the first round index whose W word is computed by message expansion.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start_valid, input, 1 bit: a 512-bit block is present on the upstream message bus.
REQ-006 SHALL have port start_ready, output, 1 bit: the controller can accept a block.
REQ-007 SHALL have port blk_first, input, 1: block begins a new message; sampled on accept.
REQ-008 SHALL have port blk_last, input, 1: block ends the message; sampled on accept.
REQ-009 SHALL have port abort, input, 1 bit: synchronous cancel of any block in flight.
REQ-010 SHALL have port load_initial, output, 1 bit: loads W[0..15] in the schedule datapath.
REQ-011 SHALL have port sched_idx, output, 8 bits: the W index driven to the schedule datapath.
REQ-012 SHALL have port sched_en, output, 1 bit: the expansion result at sched_idx is captured this cycle.
REQ-013 SHALL have port round_en, output, 1 bit: the compression round fires this cycle.
REQ-014 SHALL have port round_idx, output, 6 bits: the current round number.
REQ-015 SHALL have port k_out, output, 32 bits: the SHA-256 constant K[round_idx].
REQ-016 SHALL have port init_h, output, 1 bit: load H0..H7 with the IV constants.
REQ-017 SHALL have port update_h, output, 1 bit: feed-forward add of a..h into H0..H7.
REQ-018 SHALL have port hash_valid, output, 1 bit: the digest is final.
REQ-019 SHALL have port hash_ready, input, 1 bit: the consumer takes the digest.

Function
REQ-020 SHALL implement states IDLE, LOAD, ROUND, UPDATE, DONE; start_ready=1 only in IDLE with abort=0.
REQ-021 SHALL accept a block on the edge where start_valid&start_ready; IDLE->LOAD and blk_first/blk_last captured.
REQ-022 SHALL assert load_initial for exactly the one LOAD cycle, with init_h asserted alongside it iff the captured first=1; LOAD->ROUND.
REQ-023 SHALL in ROUND assert round_en every cycle, round_idx counting 0..63 one per cycle, sched_idx=zero-extended round_idx, and sched_en=1 iff round_idx>=SCHED_FIRST.
REQ-024 SHALL drive k_out combinationally from the package K table indexed by round_idx; in all other states k_out=K[0].
REQ-025 SHALL leave ROUND after round_idx=63 for UPDATE; the counter returns to 0 with no 6-bit wrap into a 65th round.
REQ-026 SHALL assert update_h for exactly the one UPDATE cycle; UPDATE->DONE if captured last=1, else UPDATE->IDLE.
REQ-027 SHALL hold hash_valid=1 throughout DONE until hash_valid&hash_ready, then go DONE->IDLE; start_ready=0 in DONE.
REQ-028 SHALL meet latency from the accept edge E0: LOAD during E0..E1, rounds 0..63 during E1..E65, UPDATE during E65..E66, and hash_valid high from E66.
REQ-029 SHALL on abort=1 go to IDLE on the next edge from any state, clearing the counter and captured flags and emitting no update_h or hash_valid.
REQ-030 SHALL let abort win when abort and start_valid coincide in IDLE (no accept), and when abort and hash_ready coincide in DONE (state goes to IDLE either way).
REQ-031 SHALL hold load_initial, sched_en, round_en, init_h and update_h at 0 outside their stated states.

Reset
REQ-032 SHALL on rst=1 at a clock edge enter IDLE with round_idx=0, captured flags=0, all strobes=0, hash_valid=0, and start_ready=1 from the first cycle after rst deasserts; rst overrides abort and all handshakes.
REQ-033 SHALL hold start_ready=0 while rst=1.

Structure
REQ-034 SHALL take the state enum, the 64x32 K constant table, and the IV H0..H7 constants from shared package sha_pkg, reused by the schedule and compression datapaths.
REQ-035 SHALL instantiate one sub-module, sha_round_counter: a 6-bit counter with clear/enable and a last flag at 63.

Verification
REQ-036 SHALL check single block: start_valid=1, first=1, last=1, hash_ready=1 -> load_initial+init_h at E0..E1, round_en for 64 cycles, k_out=32'h428a2f98 at round 0 and 32'hc67178f2 at round 63, update_h at E65, hash_valid one cycle at E66.
REQ-037 SHALL check two-block message: first=1,last=0 then first=0,last=1 -> first block returns to IDLE after UPDATE without hash_valid; second block gets no init_h; hash_valid only after the second UPDATE.
REQ-038 SHALL check sched_en: low for round_idx 0..15 and high for round_idx 16..63, with sched_idx equal to round_idx (e.g. 8'd32 at round 32).
REQ-039 SHALL check back-pressure: hash_ready=0 for 10 cycles -> hash_valid held and start_ready=0 throughout; on hash_ready=1 -> IDLE the next cycle.
REQ-040 SHALL check abort at round_idx=40 -> IDLE next cycle, no update_h, start_ready=1; abort and start_valid together in IDLE -> no accept.
REQ-041 SHALL check rst asserted at round 20 -> next cycle IDLE, round_idx=0, all strobes 0, and a new block then runs the normal 66-cycle sequence.
